auth_ctrl: RTL and testbench

- Receives single-byte BLE commands on the Segway's RX line (8N1 UART) and runs the rider-authorization state machine that produces pwr_up for the balance controller and steering enable.
- Sits directly downstream of the host UART transmitter: it consumes the serial stream that carries 'g' (go, 0x67) and 's' (stop, 0x73).
- Combines the UART receiver with the authorization FSM in one block.

---
 rtl/auth_ctrl.sv | 125 ++++++++++++
 tb/tb_auth_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/auth_ctrl.sv
// auth_ctrl: BLE UART receiver (8N1) feeding the rider-authorization FSM; define AUTH_ERR_CNT_EN for the saturating error counter
module auth_ctrl #(
  parameter int BAUD_DIV = 2604,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RX,
  input  logic             rider_off,
  output logic             pwr_up,
  output logic             rx_rdy,
  output logic [7:0]       rx_data,
  output logic             frm_err,
  output logic [ERR_W-1:0] err_cnt
);
  localparam logic [11:0] FULL = 12'(BAUD_DIV);
  localparam logic [11:0] HALF = 12'(BAUD_DIV / 2);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_st_t;
  typedef enum logic [1:0] {OFF, PWR1, PWR2} au_st_t;
  rx_st_t      rx_st_q, rx_st_d;
  au_st_t      au_q, au_d;
  logic        rx_s1_q, rx_s2_q, rx_p_q;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d, data_q, data_d;
  logic        rdy_q, rdy_d, ferr_q, ferr_d, pwr_q;
  logic        expire, got_g, got_s;
  assign expire  = cnt_q == 12'd1;
  assign got_g   = rdy_q && data_q == 8'h67;
  assign got_s   = rdy_q && data_q == 8'h73;
  assign pwr_up  = pwr_q;
  assign rx_rdy  = rdy_q;
  assign rx_data = data_q;
  assign frm_err = ferr_q;
  // Two-flop RX synchronizer plus a delayed copy of its output for start-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_p_q  <= 1'b1;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      rx_p_q  <= rx_s2_q;
    end
  end
  // Receiver and authorization state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      au_q    <= OFF;
      pwr_q   <= 1'b0;
    end else begin
      rx_st_q <= rx_st_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      au_q    <= au_d;
      pwr_q   <= au_d != OFF;
    end
  end
  // Receiver next state: half-bit wait to the start-bit center, then one bit period per sample
  always_comb begin
    rx_st_d = rx_st_q;
    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 12'd1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;
    case (rx_st_q)
      IDLE: if (!rx_s2_q && rx_p_q) begin
        rx_st_d = START;
        cnt_d   = HALF;
      end
      START: if (expire) begin
        rx_st_d = rx_s2_q ? IDLE : DATA;
        cnt_d   = FULL;
        idx_d   = '0;
      end
      DATA: if (expire) begin
        sh_d    = {rx_s2_q, sh_q[7:1]};
        idx_d   = idx_q + 3'd1;
        cnt_d   = FULL;
        rx_st_d = (idx_q == 3'd7) ? STOP : DATA;
      end
      default: if (expire) begin
        rx_st_d = IDLE;
        rdy_d   = rx_s2_q;
        ferr_d  = !rx_s2_q;
        data_d  = rx_s2_q ? sh_q : data_q;
      end
    endcase
  end
  // Authorization next state: 'g' authorizes, 's' requests stop, rider leaving completes a pending stop
  always_comb begin
    au_d = au_q;
    case (au_q)
      OFF:  au_d = got_g ? PWR1 : OFF;
      PWR1: au_d = got_s ? (rider_off ? OFF : PWR2) : PWR1;
      PWR2: au_d = got_g ? PWR1 : (rider_off ? OFF : PWR2);
      default: au_d = OFF;
    endcase
  end
`ifdef AUTH_ERR_CNT_EN
  logic [ERR_W-1:0] err_q;
  assign err_cnt = err_q;
  // Count framing errors and unrecognized bytes, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else if ((ferr_q || (rdy_q && !got_g && !got_s)) && err_q != '1) err_q <= err_q + ERR_W'(1);
  end
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_auth_ctrl.sv
// tb_auth_ctrl: directed UART frames against a behavioural authorization model, checked every cycle
module tb_auth_ctrl;
  localparam int B  = 16;
  localparam int BS = 2604;
  localparam int LO = B * 19 / 2 + 2;
  localparam int HI = LO + 2;
  typedef struct {int t0; logic [7:0] b; bit ok;} fr_t;
  logic clk = 0, rst_n = 0, RX = 1, rider_off = 0, RX2 = 1, ro2 = 0;
  logic pwr_up, rx_rdy, frm_err;
  logic [7:0] rx_data, err_cnt;
  logic pwr2, rdy2, ferr2;
  logic [7:0] data2, ecnt2;
  fr_t q[$];
  int cyc = 0, nerr = 0, nchk = 0, n_rdy = 0, n_ferr = 0, rdy_cyc = -1, rise_cyc = -1, lat = -1;
  int m_err = 0, rise2 = -1;
  bit m_on = 0, m_stop = 0;
  logic [7:0] last_b = 0;
  logic pwr_prev = 0, p2prev = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  auth_ctrl #(.BAUD_DIV(B), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .rider_off(rider_off), .pwr_up(pwr_up),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .frm_err(frm_err), .err_cnt(err_cnt)
  );
  auth_ctrl #(.BAUD_DIV(BS), .ERR_W(8)) slow (
    .clk(clk), .rst_n(rst_n), .RX(RX2), .rider_off(ro2), .pwr_up(pwr2),
    .rx_rdy(rdy2), .rx_data(data2), .frm_err(ferr2), .err_cnt(ecnt2)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask
  task automatic bit_out(input logic v);
    RX = v;
    repeat (B) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    q.push_back('{cyc, b, stop});
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    RX = 1'b1;
  endtask
  // Model: each sent frame must produce exactly one event inside the latency window; authorization follows the byte rules
  always @(negedge clk) begin
    fr_t f;
    bit g, s;
    g = 0;
    s = 0;
    if (!rst_n) begin
      q.delete();
      m_on = 0;
      m_stop = 0;
      last_b = 0;
      m_err = 0;
      chk("reset_outputs", {pwr_up, rx_rdy, frm_err, rx_data, err_cnt}, 0);
    end else begin
      chk("pwr_up", pwr_up, m_on);
      if (pwr_up && !pwr_prev) rise_cyc = cyc;
      if (rx_rdy || frm_err) begin
        if (q.size() == 0 || cyc < q[0].t0 + LO) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_event at cycle %0d: rx_rdy=%0b frm_err=%0b, expected none", cyc, rx_rdy, frm_err);
        end else begin
          f = q.pop_front();
          lat = cyc - f.t0;
          chk("event_kind", {rx_rdy, frm_err}, f.ok ? 2'b10 : 2'b01);
          if (rx_rdy) begin
            n_rdy++;
            rdy_cyc = cyc;
          end else n_ferr++;
          if (f.ok) begin
            last_b = f.b;
            g = f.b == 8'h67;
            s = f.b == 8'h73;
            if (!g && !s) m_err++;
          end else m_err++;
        end
      end else if (q.size() != 0 && cyc > q[0].t0 + HI) begin
        nchk++;
        nerr++;
        $display("FAIL missing_event at cycle %0d: no rx_rdy/frm_err, expected one for byte %0h", cyc, q[0].b);
        void'(q.pop_front());
      end
      if (g) begin
        m_on = 1;
        m_stop = 0;
      end else if (m_on && m_stop && rider_off) begin
        m_on = 0;
        m_stop = 0;
      end else if (s && m_on && !m_stop) begin
        if (rider_off) m_on = 0;
        else m_stop = 1;
      end
      if (m_err > 255) m_err = 255;
      chk("rx_data", rx_data, last_b);
`ifdef AUTH_ERR_CNT_EN
      chk("err_cnt", err_cnt, m_err);
`else
      chk("err_cnt", err_cnt, 0);
`endif
    end
    pwr_prev = pwr_up;
  end
  always @(negedge clk) begin
    if (pwr2 && !p2prev && rise2 < 0) rise2 = cyc;
    p2prev = pwr2;
  end
  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation did not complete, expected finish before 95000 cycles");
    $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
    $fatal(1);
  end
  initial begin
    int n0, f0, t0s;
    logic [7:0] b;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwr_up", pwr_up, 0);
    chk("rst_rx_rdy", rx_rdy, 0);
    chk("rst_frm_err", frm_err, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    send(8'h67, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("go_rx_data", rx_data, 8'h67);
    chk("go_pwr_up", pwr_up, 1);
    chk("go_latency_155", lat >= 154 && lat <= 156, 1);
    chk("go_pwr_delay", rise_cyc - rdy_cyc, 1);
    send(8'h73, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("stop_rider_on_pwr", pwr_up, 1);
    rider_off = 1;
    @(posedge clk);
    #1;
    chk("rider_off_pwr", pwr_up, 0);
    send(8'h73, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("stop_in_off_pwr", pwr_up, 0);
    n0 = n_rdy;
    send(8'h67, 1);
    send(8'h73, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_two_bytes", n_rdy - n0, 2);
    chk("b2b_rx_data", rx_data, 8'h73);
    chk("b2b_pwr_off", pwr_up, 0);
    rider_off = 0;
    n0 = n_rdy;
    f0 = n_ferr;
    send(8'h67, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("ferr_pulse", n_ferr - f0, 1);
    chk("ferr_no_rdy", n_rdy - n0, 0);
    chk("ferr_rx_data_held", rx_data, 8'h73);
    chk("ferr_pwr", pwr_up, 0);
`ifdef AUTH_ERR_CNT_EN
    chk("ferr_err_cnt", err_cnt, 1);
`endif
    n0 = n_rdy;
    f0 = n_ferr;
    RX = 0;
    repeat (B / 4) @(posedge clk);
    #1;
    RX = 1;
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_no_rdy", n_rdy - n0, 0);
    chk("glitch_no_ferr", n_ferr - f0, 0);
    send(8'h41, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("bad_rx_data", rx_data, 8'h41);
    chk("bad_in_off_pwr", pwr_up, 0);
    send(8'h67, 1);
    send(8'h41, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("bad_in_pwr1_pwr", pwr_up, 1);
`ifdef AUTH_ERR_CNT_EN
    chk("bad_err_cnt", err_cnt, 3);
`endif
    b = 8'h67;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(b[i]);
    RX = b[4];
    repeat (B / 2) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("midrst_pwr_up", pwr_up, 0);
    chk("midrst_rx_rdy", rx_rdy, 0);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_frm_err", frm_err, 0);
    RX = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (3 * B) @(posedge clk);
    #1;
    chk("midrst_no_late_byte", rx_rdy | pwr_up, 0);
    rise2 = -1;
    t0s = cyc;
    for (int i = 0; i < 10; i++) begin
      RX2 = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      repeat (BS) @(posedge clk);
      #1;
    end
    RX2 = 1;
    chk("slow_rx_data", data2, 8'h67);
    chk("slow_pwr_latency", rise2 - t0s >= 24739 && rise2 - t0s <= 24745, 1);
`ifdef AUTH_ERR_CNT_EN
    for (int i = 0; i < 300; i++) send(8'h41, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("err_saturate", err_cnt, 255);
`endif
    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
